// File: rtl/adaptive_green_scheduler.sv
// Adaptive multi-road green scheduler: picks the next road round-robin, derives its
// green time from live vehicle counts and sequences GREEN -> YELLOW -> ALL_RED on ticks.
module adaptive_green_scheduler #(
  parameter int N_ROADS    = 4,
  parameter int CW         = 8,
  parameter int TW         = 8,
  parameter int GAIN_SHIFT = 2,
  parameter int TG_MIN     = 5,
  parameter int TG_MAX     = 60,
  parameter int T_YELLOW   = 3,
  parameter int T_ALLRED   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tick,
  input  logic                        en,
  input  logic                        skip_empty,
  input  logic [N_ROADS*CW-1:0]       counts,
  input  logic [N_ROADS*TW-1:0]       tg_init,
  output logic [$clog2(N_ROADS)-1:0]  road,
  output logic [1:0]                  phase,
  output logic [TW-1:0]               green_time,
  output logic [TW-1:0]               time_left,
  output logic                        phase_start,
  output logic [N_ROADS*TW-1:0]       tg_out
);

  localparam int RW = $clog2(N_ROADS);
  localparam int SW = CW + RW;
  localparam int DW = CW + RW + 2;
  localparam int XW = DW + TW + 1;
  localparam int unsigned NR = N_ROADS;

  localparam logic signed [XW-1:0] MIN_X = XW'(TG_MIN);
  localparam logic signed [XW-1:0] MAX_X = XW'(TG_MAX);
  localparam logic [TW-1:0] MIN_T = TW'(TG_MIN);
  localparam logic [TW-1:0] MAX_T = TW'(TG_MAX);
  localparam logic [TW-1:0] YEL_T = TW'(T_YELLOW);
  localparam logic [TW-1:0] RED_T = TW'(T_ALLRED);
  localparam logic [TW-1:0] ONE_T = TW'(1);
  localparam logic [RW-1:0] LAST  = RW'(N_ROADS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    ALL_RED = 2'd3
  } phase_t;

  phase_t state, nxt_state;
  logic [RW-1:0] nxt_road;
  logic [TW-1:0] nxt_green, nxt_tl;
  logic          nxt_ps, load;
  logic          fresh;

  logic [SW-1:0]        sum;
  logic [RW-1:0]        start, sel;
  logic                 found;
  int unsigned          idx;
  logic [CW-1:0]        sel_count;
  logic [TW-1:0]        sel_init;
  logic [DW-1:0]        prod;
  logic signed [DW-1:0] diff, adj;
  logic signed [XW-1:0] tg_x;
  logic [TW-1:0]        tg_sel;

  assign phase = state;

  always_comb begin
    sum = '0;
    for (int unsigned r = 0; r < NR; r++)
      sum = sum + SW'(counts[r*CW +: CW]);
  end

  // Until the first road has been served after reset, the scan begins at road 0
  // rather than road+1.
  assign start = fresh ? '0 : ((road == LAST) ? '0 : road + 1'b1);

  always_comb begin
    sel   = start;
    found = 1'b0;
    idx   = 0;
    if (skip_empty) begin
      for (int unsigned k = 0; k < NR; k++) begin
        idx = int'(start) + k;
        if (idx >= NR) idx = idx - NR;
        if (!found && counts[idx*CW +: CW] != '0) begin
          sel   = RW'(idx);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_count = counts[sel*CW +: CW];
    sel_init  = tg_init[sel*TW +: TW];
    prod      = DW'(sel_count) * DW'(NR);
    diff      = $signed(prod - DW'(sum));
    adj       = diff >>> GAIN_SHIFT;
    tg_x      = $signed(XW'(sel_init)) + XW'(adj);
    if (skip_empty && sum == '0) tg_sel = MIN_T;
    else if (tg_x < MIN_X)       tg_sel = MIN_T;
    else if (tg_x > MAX_X)       tg_sel = MAX_T;
    else                         tg_sel = tg_x[TW-1:0];
  end

  always_comb begin
    nxt_state = state;
    nxt_road  = road;
    nxt_green = green_time;
    nxt_tl    = time_left;
    nxt_ps    = 1'b0;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        nxt_tl = '0;
        if (en) begin
          nxt_state = GREEN;
          nxt_road  = sel;
          nxt_green = tg_sel;
          nxt_tl    = tg_sel;
          nxt_ps    = 1'b1;
          load      = 1'b1;
        end
      end
      GREEN, YELLOW, ALL_RED: begin
        if (tick) begin
          if (time_left == ONE_T) begin
            nxt_ps = 1'b1;
            unique case (state)
              GREEN: begin
                nxt_state = YELLOW;
                nxt_tl    = YEL_T;
              end
              YELLOW: begin
                nxt_state = ALL_RED;
                nxt_tl    = RED_T;
              end
              default: begin
                if (en) begin
                  nxt_state = GREEN;
                  nxt_road  = sel;
                  nxt_green = tg_sel;
                  nxt_tl    = tg_sel;
                  load      = 1'b1;
                end else begin
                  nxt_state = IDLE;
                  nxt_tl    = '0;
                  nxt_ps    = 1'b0;
                end
              end
            endcase
          end else begin
            nxt_tl = time_left - ONE_T;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      road        <= '0;
      green_time  <= '0;
      time_left   <= '0;
      phase_start <= 1'b0;
      tg_out      <= '0;
      fresh       <= 1'b1;
    end else begin
      state       <= nxt_state;
      road        <= nxt_road;
      green_time  <= nxt_green;
      time_left   <= nxt_tl;
      phase_start <= nxt_ps;
      if (load) begin
        tg_out[nxt_road*TW +: TW] <= nxt_green;
        fresh                     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adaptive_green_scheduler.sv
// Directed bench for adaptive_green_scheduler at default parameters (4 roads, 8-bit fields).
module tb_adaptive_green_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        en;
  logic        skip_empty;
  logic [31:0] counts;
  logic [31:0] tg_init;
  logic [1:0]  road;
  logic [1:0]  phase;
  logic [7:0]  green_time;
  logic [7:0]  time_left;
  logic        phase_start;
  logic [31:0] tg_out;

  int checks = 0;
  int errors = 0;

  adaptive_green_scheduler #(
    .N_ROADS(4), .CW(8), .TW(8), .GAIN_SHIFT(2),
    .TG_MIN(5), .TG_MAX(60), .T_YELLOW(3), .T_ALLRED(2)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .en(en), .skip_empty(skip_empty),
    .counts(counts), .tg_init(tg_init), .road(road), .phase(phase),
    .green_time(green_time), .time_left(time_left), .phase_start(phase_start),
    .tg_out(tg_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_green(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (phase == 2'd1 && phase_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bit ok;
    en = 1'b0; tick = 1'b1; skip_empty = 1'b0;
    counts = {4{8'd10}}; tg_init = {4{8'd5}};
    reset = 1'b0;
    step();
    checks++;
    if (phase !== 2'd0 || road !== 2'd0 || green_time !== 8'd0 || time_left !== 8'd0 ||
        phase_start !== 1'b0 || tg_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: phase=%0d road=%0d green=%0d left=%0d ps=%0b tg_out=%h, required all zero",
               phase, road, green_time, time_left, phase_start, tg_out);
    end
    reset = 1'b1;
    en = 1'b1;
    wait_green(ok);
    wait_green(ok);
    checks++;
    if (!ok || road !== 2'd1) begin
      errors++;
      $display("FAIL reset_pre_green: ok=%0b road=%0d, required road 1", ok, road);
    end
    step();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (phase !== 2'd0 || road !== 2'd0 || green_time !== 8'd0 || time_left !== 8'd0 ||
        phase_start !== 1'b0 || tg_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_async: phase=%0d road=%0d green=%0d left=%0d ps=%0b tg_out=%h, required all zero",
               phase, road, green_time, time_left, phase_start, tg_out);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (phase !== 2'd0) begin
      errors++;
      $display("FAIL reset_release_idle: phase=%0d, required 0", phase);
    end
    wait_green(ok);
    checks++;
    if (!ok || road !== 2'd0 || green_time !== 8'd5) begin
      errors++;
      $display("FAIL reset_first_road: ok=%0b road=%0d green=%0d, required road 0 green 5", ok, road, green_time);
    end
  endtask

  task automatic test_calc();
    bit ok;
    int exp_tg[4] = '{28, 7, 5, 5};
    en = 1'b0; tick = 1'b1; skip_empty = 1'b0;
    counts  = {8'd15, 8'd20, 8'd22, 8'd43};
    tg_init = {4{8'd10}};
    apply_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_green(ok);
      checks++;
      if (!ok || road !== 2'(i) || green_time !== 8'(exp_tg[i]) || time_left !== 8'(exp_tg[i]) ||
          tg_out[i*8 +: 8] !== 8'(exp_tg[i])) begin
        errors++;
        $display("FAIL calc_road%0d: ok=%0b road=%0d green=%0d left=%0d tg_out=%0d, required green %0d",
                 i, ok, road, green_time, time_left, tg_out[i*8 +: 8], exp_tg[i]);
      end
    end
    checks++;
    if (tg_out !== {8'd5, 8'd5, 8'd7, 8'd28}) begin
      errors++;
      $display("FAIL calc_tg_out: got %h, required %h", tg_out, {8'd5, 8'd5, 8'd7, 8'd28});
    end
  endtask

  task automatic test_clamp();
    bit ok;
    int exp_tg[4] = '{60, 5, 5, 5};
    en = 1'b0; tick = 1'b1; skip_empty = 1'b0;
    counts  = {8'd0, 8'd0, 8'd0, 8'd200};
    tg_init = {4{8'd10}};
    apply_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_green(ok);
      checks++;
      if (!ok || road !== 2'(i) || green_time !== 8'(exp_tg[i])) begin
        errors++;
        $display("FAIL clamp_road%0d: ok=%0b road=%0d green=%0d, required green %0d",
                 i, ok, road, green_time, exp_tg[i]);
      end
    end
  endtask

  task automatic test_timing();
    bit ok;
    int exp_ph[10] = '{1, 1, 1, 1, 1, 2, 2, 2, 3, 3};
    int exp_tl[10] = '{5, 4, 3, 2, 1, 3, 2, 1, 2, 1};
    int exp_ps[10] = '{1, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    en = 1'b0; tick = 1'b1; skip_empty = 1'b0;
    counts = {4{8'd10}}; tg_init = {4{8'd5}};
    apply_reset();
    en = 1'b1;
    wait_green(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timing_start: no GREEN entry within bound");
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (phase !== 2'(exp_ph[i]) || time_left !== 8'(exp_tl[i]) || phase_start !== 1'(exp_ps[i])) begin
        errors++;
        $display("FAIL timing_cycle%0d: phase=%0d left=%0d ps=%0b, required phase=%0d left=%0d ps=%0d",
                 i, phase, time_left, phase_start, exp_ph[i], exp_tl[i], exp_ps[i]);
      end
      step();
    end
    checks++;
    if (phase !== 2'd1 || road !== 2'd1 || phase_start !== 1'b1 || time_left !== 8'd5) begin
      errors++;
      $display("FAIL timing_next_green: phase=%0d road=%0d ps=%0b left=%0d, required 1/1/1/5",
               phase, road, phase_start, time_left);
    end
    tick = 1'b0;
    step(); step(); step();
    checks++;
    if (phase !== 2'd1 || time_left !== 8'd5 || phase_start !== 1'b0) begin
      errors++;
      $display("FAIL timing_hold: phase=%0d left=%0d ps=%0b, required 1/5/0", phase, time_left, phase_start);
    end
    tick = 1'b1;
    step();
    checks++;
    if (time_left !== 8'd4) begin
      errors++;
      $display("FAIL timing_resume: left=%0d, required 4", time_left);
    end
  endtask

  task automatic test_skip();
    bit ok;
    int exp_rd[4] = '{0, 3, 0, 3};
    int exp_tg[4] = '{12, 14, 12, 14};
    en = 1'b0; tick = 1'b1; skip_empty = 1'b1;
    counts  = {8'd7, 8'd0, 8'd0, 8'd5};
    tg_init = {4{8'd10}};
    apply_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_green(ok);
      checks++;
      if (!ok || road !== 2'(exp_rd[i]) || green_time !== 8'(exp_tg[i])) begin
        errors++;
        $display("FAIL skip_seq%0d: ok=%0b road=%0d green=%0d, required road %0d green %0d",
                 i, ok, road, green_time, exp_rd[i], exp_tg[i]);
      end
    end
    en = 1'b0;
    counts = '0;
    apply_reset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_green(ok);
      checks++;
      if (!ok || road !== 2'(i % 4) || green_time !== 8'd5) begin
        errors++;
        $display("FAIL skip_zero%0d: ok=%0b road=%0d green=%0d, required road %0d green 5",
                 i, ok, road, green_time, i % 4);
      end
    end
  endtask

  task automatic test_enable();
    bit ok;
    bit seen;
    en = 1'b0; tick = 1'b1; skip_empty = 1'b0;
    counts = {4{8'd10}}; tg_init = {4{8'd5}};
    apply_reset();
    en = 1'b1;
    wait_green(ok);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (phase == 2'd2) seen = 1'b1;
    end
    checks++;
    if (!ok || !seen) begin
      errors++;
      $display("FAIL enable_reach_yellow: green=%0b yellow=%0b, required both 1", ok, seen);
    end
    en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (phase == 2'd0) seen = 1'b1;
      else if (phase == 2'd1) break;
    end
    checks++;
    if (!seen || road !== 2'd0 || green_time !== 8'd5 || time_left !== 8'd0) begin
      errors++;
      $display("FAIL enable_idle: idle=%0b phase=%0d road=%0d green=%0d left=%0d, required idle road 0 green 5 left 0",
               seen, phase, road, green_time, time_left);
    end
    step(); step(); step(); step();
    checks++;
    if (phase !== 2'd0 || time_left !== 8'd0) begin
      errors++;
      $display("FAIL enable_stay_idle: phase=%0d left=%0d, required 0/0", phase, time_left);
    end
    en = 1'b1;
    wait_green(ok);
    checks++;
    if (!ok || road !== 2'd1 || green_time !== 8'd5) begin
      errors++;
      $display("FAIL enable_resume: ok=%0b road=%0d green=%0d, required road 1 green 5", ok, road, green_time);
    end
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; en = 1'b0; skip_empty = 1'b0;
    counts = '0; tg_init = '0;
    test_reset();
    test_calc();
    test_clamp();
    test_timing();
    test_skip();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
